des_ecb_host: RTL
=================

DES_ECB_HOST -- requirements
Module: des_ecb_host

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all logic is on its rising edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-003 SHALL have port DIN, input, 8, host byte in; first byte of a block is bits [1:8] (MSB-first).
REQ-004 SHALL have ports DIN_VLD (input, 1) and DIN_RDY (output, 1); a byte transfers when both are high.
REQ-005 SHALL have port KSEL, input, 1, sampled with the first byte of a block: 1 = key block, 0 = data block.
REQ-006 SHALL have port ENC_IN, input, 1, sampled with the first byte of a data block: 1 = encrypt, 0 = decrypt.
REQ-007 SHALL have port DOUT, output, 8, result byte out, MSB-first.
REQ-008 SHALL have ports DOUT_VLD (output, 1), DOUT_RDY (input, 1) and DOUT_LAST (output, 1); DOUT_LAST is high on the 8th byte.
REQ-009 SHALL have ports DES_DIN, DES_KEY (outputs, 64), DES_DRDY, DES_KRDY, DES_ENC, DES_EN (outputs, 1), DES_BSY, DES_KVLD, DES_DVLD (inputs, 1) and DES_DOUT (input, 64), all connecting to the DES core.
REQ-010 SHALL have port ERR, output, 1, one-cycle error pulse.

Function
REQ-011 SHALL implement the states IDLE, LOAD, KSTB, DSTB, WAIT and UNLOAD.
REQ-012 IDLE: DIN_RDY=1; first accepted byte latches KSEL/ENC_IN, byte counter:=1, -> LOAD.
REQ-013 LOAD: DIN_RDY=1; shifts bytes into a 64-bit assembly register; after the 8th byte -> KSTB if KSEL latched 1, else DSTB; KSEL/ENC_IN changes mid-block are ignored.
REQ-014 KSTB: waits for DES_BSY=0, drives DES_KEY=assembled value, pulses DES_KRDY for exactly one cycle, sets key_ok, -> IDLE; a key block produces no output.
REQ-015 DSTB: if key_ok=0, pulses ERR, discards the block, -> IDLE; otherwise waits for DES_BSY=0, then pulses DES_DRDY for exactly one cycle with DES_DIN=assembled value, DES_ENC=latched ENC_IN, -> WAIT.
REQ-016 DES_DIN, DES_KEY and DES_ENC SHALL be registered and held stable from the strobe cycle until the next strobe.
REQ-017 WAIT: on a DES_DVLD pulse, captures DES_DOUT into the output shift register, -> UNLOAD; the expected core latency is 17-18 cycles from DES_DRDY.
REQ-018 UNLOAD: DOUT_VLD=1; DOUT presents bytes [1:8] first; advances on DOUT_VLD&DOUT_RDY; DOUT_LAST=1 on the 8th byte; after the 8th transfer -> IDLE.
REQ-019 DIN_RDY SHALL be 0 in KSTB, DSTB, WAIT and UNLOAD; no input byte is accepted there.
REQ-020 DES_KRDY and DES_DRDY SHALL never be high simultaneously, and neither SHALL be high while DES_BSY=1.
REQ-021 DES_DVLD arriving outside WAIT SHALL be ignored.
REQ-022 DES_EN SHALL be constant 1 after reset.
REQ-023 The 3-bit byte counter SHALL wrap from 7 to 0 on the 8th byte; both LOAD and UNLOAD reuse it.
REQ-024 DOUT_RDY held low SHALL stall UNLOAD indefinitely with DOUT and DOUT_VLD stable.

Reset
REQ-025 On RST=1: state=IDLE, counter=0, key_ok=0, DIN_RDY=0 during reset, DOUT_VLD=0, DOUT_LAST=0, DOUT=0, ERR=0, DES_KRDY=0, DES_DRDY=0, DES_ENC=1, DES_DIN=0, DES_KEY=0, DES_EN=0.
REQ-026 Reset mid-operation SHALL abort any partial block or unload with no further strobes; the DES core is reset by its own reset path.

Configuration
REQ-027 Macro DES_ECB_HOST_TIMEOUT_EN SHALL control the WAIT-state watchdog.
REQ-028 With DES_ECB_HOST_TIMEOUT_EN defined: a 6-bit counter cleared on entry to WAIT; if DES_DVLD is absent for 32 cycles, ERR pulses one cycle and state -> IDLE with no output.
REQ-029 Without DES_ECB_HOST_TIMEOUT_EN: no watchdog logic is present; WAIT persists until DES_DVLD.

Verification
REQ-030 Key block 13 34 57 79 9B BC DF F1 (KSEL=1), then data 01 23 45 67 89 AB CD EF (ENC_IN=1) -> DOUT 85 E8 13 54 0F 0A B4 05, DOUT_LAST on the 8th byte, one DES_KRDY pulse and one DES_DRDY pulse.
REQ-031 Same key, data 85 E8 13 54 0F 0A B4 05 with ENC_IN=0 -> DOUT 01 23 45 67 89 AB CD EF.
REQ-032 Data block immediately after reset with no key -> ERR pulses once, no DES_DRDY, DIN_RDY=1 next cycle.
REQ-033 DOUT_RDY held low for 20 cycles during UNLOAD -> DOUT/DOUT_VLD stable, DIN_RDY=0, no byte lost.
REQ-034 RST asserted after the 4th byte of a data block -> all outputs at reset values; the next full block processes correctly.
REQ-035 With DES_ECB_HOST_TIMEOUT_EN, DES_DVLD tied 0 -> ERR pulses 32 cycles after entering WAIT, state returns to IDLE.

Source files
------------

// File: rtl/des_ecb_host_if.sv
// Host byte-stream handshake plus DES core strobe/data bundle for des_ecb_host.
// slave = the host controller's view, master = the host/core environment's view.
interface des_ecb_host_if;
   logic [7:0]  DIN;
   logic        DIN_VLD;
   logic        DIN_RDY;
   logic        KSEL;
   logic        ENC_IN;
   logic [7:0]  DOUT;
   logic        DOUT_VLD;
   logic        DOUT_RDY;
   logic        DOUT_LAST;
   logic [63:0] DES_DIN;
   logic [63:0] DES_KEY;
   logic        DES_DRDY;
   logic        DES_KRDY;
   logic        DES_ENC;
   logic        DES_EN;
   logic        DES_BSY;
   logic        DES_KVLD;
   logic        DES_DVLD;
   logic [63:0] DES_DOUT;
   logic        ERR;

   modport slave (
      input  DIN, DIN_VLD, KSEL, ENC_IN, DOUT_RDY,
             DES_BSY, DES_KVLD, DES_DVLD, DES_DOUT,
      output DIN_RDY, DOUT, DOUT_VLD, DOUT_LAST,
             DES_DIN, DES_KEY, DES_DRDY, DES_KRDY, DES_ENC, DES_EN, ERR
   );

   modport master (
      output DIN, DIN_VLD, KSEL, ENC_IN, DOUT_RDY,
             DES_BSY, DES_KVLD, DES_DVLD, DES_DOUT,
      input  DIN_RDY, DOUT, DOUT_VLD, DOUT_LAST,
             DES_DIN, DES_KEY, DES_DRDY, DES_KRDY, DES_ENC, DES_EN, ERR
   );
endinterface

// File: rtl/des_ecb_host.sv
// DES ECB host: packs 8 host bytes into a key/data block, strobes the DES core, unpacks the result.
// Latency: 8 load cycles + strobe + core (~17) + 8 unload cycles; DES_ECB_HOST_TIMEOUT_EN adds a WAIT watchdog.
// Backpressure: DIN_RDY low outside IDLE/LOAD; DOUT_RDY low stalls UNLOAD indefinitely.
module des_ecb_host (
   input  logic          CLK,
   input  logic          RST,
   des_ecb_host_if.slave hif
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_KSTB   = 3'd2;
   localparam logic [2:0] ST_DSTB   = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_UNLOAD = 3'd5;

   logic [2:0]  state;
   logic [2:0]  cnt;
   logic        key_ok;
   logic        ksel_l;
   logic        enc_l;
   logic [63:0] asm_reg;
   logic [63:0] out_sr;
   logic [63:0] des_din;
   logic [63:0] des_key;
   logic        des_enc;
   logic        des_en;
   logic        krdy;
   logic        drdy;
   logic        err;
   logic        din_rdy;
   logic        din_xfer;
   logic        dout_vld;
   logic        dout_xfer;
`ifdef DES_ECB_HOST_TIMEOUT_EN
   logic [5:0]  tcnt;
`endif

   // Ready is forced low while reset is held, not just after the reset edge.
   assign din_rdy   = ~RST & ((state == ST_IDLE) | (state == ST_LOAD));
   assign din_xfer  = hif.DIN_VLD & din_rdy;
   assign dout_vld  = (state == ST_UNLOAD);
   assign dout_xfer = dout_vld & hif.DOUT_RDY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         cnt     <= 3'd0;
         key_ok  <= 1'b0;
         ksel_l  <= 1'b0;
         enc_l   <= 1'b1;
         asm_reg <= 64'd0;
         out_sr  <= 64'd0;
         des_din <= 64'd0;
         des_key <= 64'd0;
         des_enc <= 1'b1;
         des_en  <= 1'b0;
         krdy    <= 1'b0;
         drdy    <= 1'b0;
         err     <= 1'b0;
`ifdef DES_ECB_HOST_TIMEOUT_EN
         tcnt    <= 6'd0;
`endif
      end else begin
         krdy   <= 1'b0;
         drdy   <= 1'b0;
         err    <= 1'b0;
         des_en <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (din_xfer) begin
                  asm_reg <= {asm_reg[55:0], hif.DIN};
                  ksel_l  <= hif.KSEL;
                  enc_l   <= hif.ENC_IN;
                  cnt     <= 3'd1;
                  state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (din_xfer) begin
                  asm_reg <= {asm_reg[55:0], hif.DIN};
                  cnt     <= cnt + 3'd1;
                  if (cnt == 3'd7)
                     state <= ksel_l ? ST_KSTB : ST_DSTB;
               end
            end
            ST_KSTB: begin
               if (!hif.DES_BSY) begin
                  des_key <= asm_reg;
                  krdy    <= 1'b1;
                  key_ok  <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            ST_DSTB: begin
               // A data block with no key loaded is dropped without touching the core.
               if (!key_ok) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else if (!hif.DES_BSY) begin
                  des_din <= asm_reg;
                  des_enc <= enc_l;
                  drdy    <= 1'b1;
                  state   <= ST_WAIT;
`ifdef DES_ECB_HOST_TIMEOUT_EN
                  tcnt    <= 6'd0;
`endif
               end
            end
            ST_WAIT: begin
               if (hif.DES_DVLD) begin
                  out_sr <= hif.DES_DOUT;
                  cnt    <= 3'd0;
                  state  <= ST_UNLOAD;
               end
`ifdef DES_ECB_HOST_TIMEOUT_EN
               else if (tcnt == 6'd31) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 6'd1;
               end
`endif
            end
            ST_UNLOAD: begin
               if (dout_xfer) begin
                  out_sr <= {out_sr[55:0], 8'h00};
                  cnt    <= cnt + 3'd1;
                  if (cnt == 3'd7)
                     state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign hif.DIN_RDY   = din_rdy;
   assign hif.DOUT      = out_sr[63:56];
   assign hif.DOUT_VLD  = dout_vld;
   assign hif.DOUT_LAST = dout_vld & (cnt == 3'd7);
   assign hif.DES_DIN   = des_din;
   assign hif.DES_KEY   = des_key;
   assign hif.DES_ENC   = des_enc;
   assign hif.DES_EN    = des_en;
   assign hif.DES_KRDY  = krdy;
   assign hif.DES_DRDY  = drdy;
   assign hif.ERR       = err;

endmodule
